// File: rtl/lif_layer.sv
// Time-multiplexed layer of leaky integrate-and-fire neurons: serial accumulate
// against a writable weight memory, then leak, threshold, refractory and optional WTA.
module lif_layer #(
  parameter int          NUM_INPUTS  = 4,
  parameter int          NUM_NEURONS = 2,
  parameter int          WEIGHT_SIZE = 8,
  parameter int          POT_SIZE    = 16,
  parameter int          THRESH      = 15,
  parameter int          RESET       = 0,
  parameter int unsigned LEAK        = 1,
  parameter int unsigned REFRAC      = 2,
  parameter int          WTA         = 0,
  localparam int NA = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  localparam int IA = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_INPUTS-1:0]           spike_in,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            state_clr,
  input  logic                            w_en,
  input  logic [NA-1:0]                   w_neuron,
  input  logic [IA-1:0]                   w_input,
  input  logic [WEIGHT_SIZE-1:0]          w_data,
  output logic [NUM_NEURONS-1:0]          spike_out,
  output logic                            out_valid,
  output logic [1:0]                      dbg_state_o,
  output logic [NUM_NEURONS*POT_SIZE-1:0] dbg_pot_o
);

  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam int XW = ((POT_SIZE > 32) ? POT_SIZE : 32) + 2;

  localparam logic signed [POT_SIZE-1:0] RESET_P  = POT_SIZE'(RESET);
  localparam logic signed [XW-1:0]       RESET_X  = XW'(RESET);
  localparam logic signed [XW-1:0]       THRESH_X = XW'(THRESH);
  localparam logic signed [XW-1:0]       LEAK_X   = XW'(LEAK);
  localparam logic [RW-1:0]              REFRAC_R = RW'(REFRAC);
  localparam logic [IA-1:0]              LAST_IDX = IA'(NUM_INPUTS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_UPDATE = 2'd2,
    S_OUT    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [NUM_INPUTS-1:0]         spk_q;
  logic [IA-1:0]                 idx_q;
  logic [NUM_NEURONS-1:0]        spike_q, spike_d;
  logic signed [WEIGHT_SIZE-1:0] w_q    [NUM_NEURONS][NUM_INPUTS];
  logic signed [POT_SIZE-1:0]    pot_q  [NUM_NEURONS];
  logic signed [POT_SIZE-1:0]    pot_d  [NUM_NEURONS];
  logic signed [POT_SIZE-1:0]    leak_v [NUM_NEURONS];
  logic [RW-1:0]                 ref_q  [NUM_NEURONS];
  logic [RW-1:0]                 ref_d  [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]        cand;
  logic [NUM_NEURONS-1:0]        fire;
  logic                          w_in_range;

  // Adds a sign-extended weight; clamps to the potential range on overflow.
  function automatic logic signed [POT_SIZE-1:0] sat_add(
    input logic signed [POT_SIZE-1:0]    p,
    input logic signed [WEIGHT_SIZE-1:0] w
  );
    logic signed [POT_SIZE:0] s;
    s = $signed({p[POT_SIZE-1], p}) +
        $signed({{(POT_SIZE + 1 - WEIGHT_SIZE){w[WEIGHT_SIZE-1]}}, w});
    if (s[POT_SIZE] != s[POT_SIZE-1])
      return s[POT_SIZE] ? {1'b1, {(POT_SIZE-1){1'b0}}} : {1'b0, {(POT_SIZE-1){1'b1}}};
    return s[POT_SIZE-1:0];
  endfunction

  function automatic logic signed [POT_SIZE-1:0] leak_toward_reset(
    input logic signed [POT_SIZE-1:0] p
  );
    logic signed [XW-1:0] x;
    logic signed [XW-1:0] t;
    x = {{(XW - POT_SIZE){p[POT_SIZE-1]}}, p};
    t = x;
    if (x > RESET_X) begin
      t = x - LEAK_X;
      if (t < RESET_X) t = RESET_X;
    end else if (x < RESET_X) begin
      t = x + LEAK_X;
      if (t > RESET_X) t = RESET_X;
    end
    return t[POT_SIZE-1:0];
  endfunction

  function automatic logic at_threshold(input logic signed [POT_SIZE-1:0] p);
    logic signed [XW-1:0] x;
    x = {{(XW - POT_SIZE){p[POT_SIZE-1]}}, p};
    return x >= THRESH_X;
  endfunction

  assign w_in_range  = (32'(w_neuron) < NUM_NEURONS) && (32'(w_input) < NUM_INPUTS);
  assign spike_out   = spike_q;
  assign dbg_state_o = state_q;

  always_comb begin
    dbg_pot_o = '0;
    for (int n = 0; n < NUM_NEURONS; n++) dbg_pot_o[n*POT_SIZE +: POT_SIZE] = pot_q[n];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Handshake: a timestep is accepted on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE, out_valid pulses for one cycle with spike_out stable.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_ACCUM;
      end
      S_ACCUM:  if (idx_q == LAST_IDX) state_d = S_UPDATE;
      S_UPDATE: state_d = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    spike_d = spike_q;
    cand    = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      pot_d[n]  = pot_q[n];
      ref_d[n]  = ref_q[n];
      leak_v[n] = leak_toward_reset(pot_q[n]);
      cand[n]   = (ref_q[n] == '0) && at_threshold(leak_v[n]);
    end
    // With WTA only the lowest-index candidate survives (isolate lowest set bit).
    fire = (WTA != 0) ? (cand & (~cand + NUM_NEURONS'(1))) : cand;

    case (state_q)
      S_IDLE: begin
        if (state_clr) begin
          for (int n = 0; n < NUM_NEURONS; n++) begin
            pot_d[n] = RESET_P;
            ref_d[n] = '0;
          end
        end
      end
      S_ACCUM: begin
        for (int n = 0; n < NUM_NEURONS; n++)
          if ((ref_q[n] == '0) && spk_q[idx_q]) pot_d[n] = sat_add(pot_q[n], w_q[n][idx_q]);
      end
      S_UPDATE: begin
        spike_d = fire;
        for (int n = 0; n < NUM_NEURONS; n++) begin
          if (ref_q[n] != '0) begin
            ref_d[n] = ref_q[n] - 1'b1;
            pot_d[n] = RESET_P;
          end else if (fire[n]) begin
            ref_d[n] = REFRAC_R;
            pot_d[n] = RESET_P;
          end else if ((WTA != 0) && (cand != '0)) begin
            pot_d[n] = RESET_P;
          end else begin
            pot_d[n] = leak_v[n];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spk_q   <= '0;
      idx_q   <= '0;
      spike_q <= '0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
        pot_q[n] <= RESET_P;
        ref_q[n] <= '0;
        for (int i = 0; i < NUM_INPUTS; i++) w_q[n][i] <= '0;
      end
    end else begin
      spike_q <= spike_d;
      for (int n = 0; n < NUM_NEURONS; n++) begin
        pot_q[n] <= pot_d[n];
        ref_q[n] <= ref_d[n];
      end
      if (state_q == S_IDLE) begin
        if (in_valid) begin
          spk_q <= spike_in;
          idx_q <= '0;
        end
        // A write on the accept edge lands before the first ACCUM read.
        if (w_en && w_in_range) w_q[w_neuron][w_input] <= w_data;
      end else if (state_q == S_ACCUM) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lif_layer.sv
// Directed bench for lif_layer: default layer, a WTA layer and an 8-bit-potential layer
// share one stimulus stream; each check targets the instance it concerns.
module tb_lif_layer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  spike_in;
  logic        in_valid, state_clr, w_en;
  logic [0:0]  w_neuron;
  logic [1:0]  w_input;
  logic [7:0]  w_data;

  logic        in_ready, out_valid;
  logic [1:0]  spike_out, dbg_state;
  logic [31:0] dbg_pot;
  logic        wta_ready, wta_valid;
  logic [1:0]  wta_spike, wta_state;
  logic [31:0] wta_pot;
  logic        sat_ready, sat_valid;
  logic [1:0]  sat_spike, sat_state;
  logic [15:0] sat_pot;

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  lif_layer u_dut (
    .clk(clk), .rst(rst), .spike_in(spike_in), .in_valid(in_valid), .in_ready(in_ready),
    .state_clr(state_clr), .w_en(w_en), .w_neuron(w_neuron), .w_input(w_input),
    .w_data(w_data), .spike_out(spike_out), .out_valid(out_valid),
    .dbg_state_o(dbg_state), .dbg_pot_o(dbg_pot)
  );

  lif_layer #(.WTA(1)) u_wta (
    .clk(clk), .rst(rst), .spike_in(spike_in), .in_valid(in_valid), .in_ready(wta_ready),
    .state_clr(state_clr), .w_en(w_en), .w_neuron(w_neuron), .w_input(w_input),
    .w_data(w_data), .spike_out(wta_spike), .out_valid(wta_valid),
    .dbg_state_o(wta_state), .dbg_pot_o(wta_pot)
  );

  lif_layer #(.POT_SIZE(8)) u_sat (
    .clk(clk), .rst(rst), .spike_in(spike_in), .in_valid(in_valid), .in_ready(sat_ready),
    .state_clr(state_clr), .w_en(w_en), .w_neuron(w_neuron), .w_input(w_input),
    .w_data(w_data), .spike_out(sat_spike), .out_valid(sat_valid),
    .dbg_state_o(sat_state), .dbg_pot_o(sat_pot)
  );

  typedef struct {
    logic       clr;
    logic       wr;
    logic       wn;
    logic [1:0] wi;
    logic [7:0] wd;
    logic [3:0] spk;
    logic [1:0] exp_spk;
    int         exp_p0;
    int         exp_p1;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    spike_in  = '0;
    in_valid  = 1'b0;
    state_clr = 1'b0;
    w_en      = 1'b0;
    w_neuron  = '0;
    w_input   = '0;
    w_data    = '0;
  endtask

  task automatic write_w(input logic wn, input logic [1:0] wi, input logic [7:0] wd);
    @(negedge clk);
    w_en = 1'b1; w_neuron = wn; w_input = wi; w_data = wd;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    state_clr = 1'b1;
    @(negedge clk);
    state_clr = 1'b0;
  endtask

  // Presents one timestep and returns at the negedge where out_valid is seen.
  task automatic do_step(input logic [3:0] spk, input logic clr, input logic wr,
                         input logic wn, input logic [1:0] wi, input logic [7:0] wd,
                         input bit disturb, output int lat, output bit busy_ok);
    @(negedge clk);
    spike_in = spk; in_valid = 1'b1; state_clr = clr;
    w_en = wr; w_neuron = wn; w_input = wi; w_data = wd;
    lat     = 0;
    busy_ok = 1'b1;
    while (1) begin
      @(negedge clk);
      in_valid = 1'b0; state_clr = 1'b0; w_en = 1'b0;
      spike_in = 4'($urandom_range(0, 15));
      lat++;
      if (in_ready) busy_ok = 1'b0;
      if (disturb && lat == 2) begin
        state_clr = 1'b1; w_en = 1'b1; w_neuron = 1'b0; w_input = 2'd0; w_data = 8'd100;
      end
      if (out_valid || lat >= 20) break;
    end
    spike_in = '0;
  endtask

  initial begin
    int   lat;
    bit   busy_ok;
    bit   seen;
    logic [1:0] e;
    logic signed [15:0] p0, p1;
    logic signed [7:0]  sp1;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 2'b01, 0, 0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 2'b00, 0, 0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 2'b00, 0, 0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 2'b01, 0, 0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h03, 4'b0001, 2'b00, 2, 0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 4'b0001, 2'b00, 4, 0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, 2'b00, 3, 0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 2'd0, 8'hFD, 4'b0001, 2'b00, 5, -2};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, 2'b00, 4, -1};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 4'b0001, 2'b00, 2, -2};

    // Reset held with random inputs.
    idle_inputs();
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      spike_in  = 4'($urandom_range(0, 15));
      in_valid  = 1'($urandom_range(0, 1));
      state_clr = 1'($urandom_range(0, 1));
      w_en      = 1'($urandom_range(0, 1));
      w_data    = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    chk("rst_spike_out", spike_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_state", dbg_state, 0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    p0 = dbg_pot[15:0];
    chk("rst_pot0", p0, 0);

    // Table: fire, refractory, leak in both directions, clear-with-accept.
    for (int i = 0; i < 4; i++) write_w(1'b0, 2'(i), 8'd5);
    for (int k = 0; k < NV; k++) begin
      exp_q.push_back(vecs[k].exp_spk);
      do_step(vecs[k].spk, vecs[k].clr, vecs[k].wr, vecs[k].wn, vecs[k].wi, vecs[k].wd,
              1'b0, lat, busy_ok);
      e  = exp_q.pop_front();
      p0 = dbg_pot[15:0];
      p1 = dbg_pot[31:16];
      chk($sformatf("v%0d_latency", k), lat, 6);
      chk($sformatf("v%0d_busy", k), busy_ok, 1);
      chk($sformatf("v%0d_spike", k), spike_out, e);
      chk($sformatf("v%0d_pot0", k), p0, vecs[k].exp_p0);
      chk($sformatf("v%0d_pot1", k), p1, vecs[k].exp_p1);
      @(negedge clk);
      chk($sformatf("v%0d_ready_after", k), in_ready, 1);
      chk($sformatf("v%0d_valid_pulse", k), out_valid, 0);
      chk($sformatf("v%0d_spike_held", k), spike_out, e);
    end

    // Negative saturation (8-bit potential) versus the 16-bit layer.
    pulse_clr();
    for (int i = 0; i < 4; i++) write_w(1'b1, 2'(i), 8'h80);
    do_step(4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, lat, busy_ok);
    sp1 = sat_pot[15:8];
    p1  = dbg_pot[31:16];
    chk("sat_pot1", sp1, -127);
    chk("sat_spike", sat_spike, 2'b01);
    chk("wide_pot1", p1, -511);
    chk("wide_spike", spike_out, 2'b01);
    p1 = wta_pot[31:16];
    chk("wta_inhibit_neg", p1, 0);

    // Winner-take-all.
    pulse_clr();
    for (int i = 0; i < 8; i++) write_w(1'(i / 4), 2'(i % 4), 8'd5);
    do_step(4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, lat, busy_ok);
    p0 = wta_pot[15:0];
    p1 = wta_pot[31:16];
    chk("wta1_spike", wta_spike, 2'b01);
    chk("wta1_pot0", p0, 0);
    chk("wta1_pot1", p1, 0);
    chk("nowta1_spike", spike_out, 2'b11);
    do_step(4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, lat, busy_ok);
    chk("wta2_spike", wta_spike, 2'b10);
    chk("nowta2_spike", spike_out, 2'b00);

    // Writes and clears while busy are ignored.
    do_step(4'b0001, 1'b1, 1'b1, 1'b0, 2'd0, 8'd3, 1'b0, lat, busy_ok);
    p0 = dbg_pot[15:0];
    chk("busy_pre_pot0", p0, 2);
    do_step(4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, lat, busy_ok);
    p0 = dbg_pot[15:0];
    chk("busy_dist_pot0", p0, 4);
    do_step(4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, lat, busy_ok);
    p0 = dbg_pot[15:0];
    chk("busy_post_pot0", p0, 6);

    // Reset asserted in the second ACCUM cycle aborts the timestep.
    @(negedge clk);
    spike_in = 4'b1111; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_state", dbg_state, 0);
    chk("abort_spike_out", spike_out, 0);
    repeat (2) @(negedge clk);
    rst  = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", seen, 0);
    do_step(4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, lat, busy_ok);
    p0 = dbg_pot[15:0];
    chk("abort_latency", lat, 6);
    chk("abort_w_cleared_pot0", p0, 0);
    chk("abort_spike_after", spike_out, 2'b00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lif_layer.md
# lif_layer

Parametrised layer of leaky integrate-and-fire neurons. It replaces the combinational-accumulate/controller-reset pair with a time-multiplexed, single-clock layer. Each presented spike vector is serially accumulated against a writable per-synapse weight memory, then leaked and thresholded. Per-neuron refractory counters and optional winner-take-all lateral inhibition are applied. It sits between an input spike encoder and the next layer, exchanging one timestep per valid/ready handshake.

## Interface
- NUM_INPUTS, 4, synapses per neuron (≥1)
- NUM_NEURONS, 2, neurons in layer (≥1)
- WEIGHT_SIZE, 8, signed weight width
- POT_SIZE, 16, signed membrane potential width (≥ WEIGHT_SIZE)
- THRESH, 15, fire when potential ≥ THRESH (signed compare)
- RESET, 0, potential after fire/inhibit/clear
- LEAK, 1, magnitude decayed toward RESET per timestep (unsigned)
- REFRAC, 2, timesteps a neuron ignores input after firing
- WTA, 0, 1 = only lowest-index firing neuron spikes, others inhibited
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- spike_in  in  NUM_INPUTS  input spike vector for one timestep
- in_valid  in  1  spike_in valid
- in_ready  out  1  layer idle, can accept a timestep
- state_clr  in  1  clear potentials/refractory counters (honoured in IDLE only)
- w_en  in  1  weight write strobe (honoured in IDLE only)
- w_neuron  in  max(1,$clog2(NUM_NEURONS))  weight row
- w_input  in  max(1,$clog2(NUM_INPUTS))  weight column
- w_data  in  WEIGHT_SIZE  signed weight
- spike_out  out  NUM_NEURONS  registered output spikes, held until next out_valid
- out_valid  out  1  one-cycle pulse, spike_out updated

## Operation
- States: IDLE, ACCUM, UPDATE, OUT.
- IDLE: in_ready=1. in_valid=1 latches spike_in, clears input index, goes to ACCUM. state_clr=1 sets every potential to RESET and every refractory count to 0. If state_clr and in_valid coincide, the clear applies first. w_en writes weight[w_neuron][w_input]. Out-of-range addresses are ignored. A write coincident with acceptance is used by that timestep.
- w_en/state_clr outside IDLE: ignored, no side effects.
- ACCUM: one input index per cycle, i = 0..NUM_INPUTS-1. For every neuron in parallel with refractory count 0 and latched bit i set, potential += sign-extended weight. The sum saturates to [−2^(POT_SIZE−1), 2^(POT_SIZE−1)−1]. Exit to UPDATE after index NUM_INPUTS-1.
- UPDATE, per neuron:
  - Refractory count > 0: decrement; potential = RESET; no fire.
  - Otherwise leak: if potential > RESET, potential = max(potential−LEAK, RESET). If < RESET, potential = min(potential+LEAK, RESET).
  - Candidate if leaked potential ≥ THRESH.
- WTA=0: every candidate fires: spike bit set, potential = RESET, refractory = REFRAC.
- WTA=1: the lowest-index candidate fires as above. Every other non-refractory neuron has potential set to RESET, with no refractory. With no candidate, nothing is inhibited.
- OUT: spike_out registered, out_valid=1 for one cycle, then IDLE.
- Weights, potentials, and refractory counts reset to 0, RESET, and 0.

## Timing
- Reset (rst=0): state IDLE, spike_out=0, out_valid=0, in_ready=1 once rst=1. Assertion mid-timestep aborts immediately; the partial timestep is discarded.
- Accept edge = cycle 0. ACCUM occupies cycles 1..NUM_INPUTS, UPDATE is cycle NUM_INPUTS+1, out_valid is high in cycle NUM_INPUTS+2.
- in_ready is low from cycle 1 through NUM_INPUTS+2 and high again in cycle NUM_INPUTS+3.
- Throughput: one timestep per NUM_INPUTS+3 cycles.
- in_ready is a combinational decode of state only; no path from in_valid.

## Test plan
- Reset: hold rst=0 with random inputs → spike_out=0, out_valid=0; after release, in_ready=1.
- Single fire: row0 weights all 5, spike_in=4'b1111 accepted at cycle 0 → out_valid in cycle 6, spike_out=2'b01, neuron0 potential 0.
- Refractory: repeat 4'b1111 for three more timesteps → spike_out 00, 00, 01.
- Leak/saturate:
  - weight[0][0]=3, spike_in=4'b0001 → potential 2, then 4. A zero timestep gives 3.
  - POT_SIZE=8, row1 weights −128, spike_in=4'b1111 → potential −127 after saturation and leak.
- WTA=1, both rows 5, 4'b1111 → spike_out=01, neuron1 potential 0. Next timestep 4'b1111 → spike_out=10 while neuron0 is refractory.
- Robustness:
  - w_en and state_clr during ACCUM → no effect.
  - rst=0 in cycle 2 of ACCUM → IDLE, no out_valid.
  - state_clr with in_valid in IDLE → timestep starts from RESET.
